// File: rtl/score_event_ctrl_pkg.sv
// score_event_ctrl_pkg
//   Shared definitions for the score event controller and the high-score
//   block it feeds: leaderboard page codes, FSM state encodings and the
//   default score cap.
//   No ports (package).
package score_event_ctrl_pkg;

  // Page select codes, shared with highscoreSystem
  localparam logic [1:0] DEC_SELF  = 2'b00;
  localparam logic [1:0] DEC_ONE   = 2'b01;
  localparam logic [1:0] DEC_TWO   = 2'b10;
  localparam logic [1:0] DEC_THREE = 2'b11;

  // Controller FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PLAY   = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_REVIEW = 3'd4;

  // Score counter width and default cap (3-digit display)
  localparam int SCORE_W           = 10;
  localparam int MAX_SCORE_DEFAULT = 999;

  typedef logic [1:0] decider_t;

  // Pages cycle SELF -> ONE -> TWO -> THREE -> SELF
  function automatic decider_t next_page(input decider_t d);
    return d + 2'd1;
  endfunction

endpackage

// File: rtl/score_event_ctrl_rise_detect.sv
// rise_detect
//   Registers the previous value of a synchronous level and flags the cycle
//   in which it goes from low to high.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-low reset
//     d    - synchronous level input
//     rise - combinational, high while d=1 and previous d=0
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  // The previous value updates every cycle regardless of controller state,
  // so a level held across a state change never looks like a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/score_event_ctrl.sv
// score_event_ctrl
//   Turns game-logic levels into the increment strobe, en commit/review flag
//   and decider page select consumed by highscoreSystem. Counts food events
//   during play up to a cap, sequences a clean commit edge at game over, then
//   auto-cycles the leaderboard pages (with manual advance on key_view).
//   Parameters:
//     DWELL_CYCLES - cycles each leaderboard page is shown
//     DWELL_W      - dwell counter width, must hold DWELL_CYCLES-1
//     MAX_SCORE    - last score value for which an increment is issued
//   Ports:
//     clk        - system clock
//     rst        - asynchronous active-low reset
//     start      - level, rising edge starts a game (from IDLE or REVIEW)
//     food_eaten - level, rising edge scores one point during play
//     game_over  - level, sampled only while playing
//     key_view   - debounced level, rising edge advances the review page
//     increment  - registered one-cycle strobe
//     en         - registered, high in ARM, COMMIT and REVIEW
//     decider    - registered page select
//     playing    - registered, high in PLAY
module score_event_ctrl
  import score_event_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DWELL_W      = 26,
  parameter int MAX_SCORE    = MAX_SCORE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       food_eaten,
  input  logic       game_over,
  input  logic       key_view,
  output logic       increment,
  output logic       en,
  output logic [1:0] decider,
  output logic       playing
);

  localparam logic [SCORE_W-1:0] SCORE_CAP  = SCORE_W'(MAX_SCORE);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic               start_rise;
  logic               food_rise;
  logic               key_rise;
  logic               food_strobe;
  logic [2:0]         state;
  logic [SCORE_W-1:0] score;
  logic [DWELL_W-1:0] dwell;

  rise_detect u_start_rise (.clk(clk), .rst(rst), .d(start),      .rise(start_rise));
  rise_detect u_food_rise  (.clk(clk), .rst(rst), .d(food_eaten), .rise(food_rise));
  rise_detect u_key_rise   (.clk(clk), .rst(rst), .d(key_view),   .rise(key_rise));

  // A food edge only scores while the counter is still below the cap
  assign food_strobe = food_rise && (score < SCORE_CAP);

  // Controller FSM with its score and dwell counters. All outputs are
  // registered so the high-score block sees glitch-free levels.
  //
  // ARM normally lasts one cycle with en already high. If game over arrives
  // together with a scored food edge, ARM is entered with en still low while
  // that food strobe is on the wire; ARM then spends one extra cycle raising
  // en with increment low, so the commit strobe is always a separate rising
  // edge preceded by at least one cycle of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      score     <= '0;
      dwell     <= '0;
      increment <= 1'b0;
      en        <= 1'b0;
      decider   <= DEC_SELF;
      playing   <= 1'b0;
    end else begin
      increment <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state   <= ST_PLAY;
            playing <= 1'b1;
            score   <= '0;
          end
        end
        ST_PLAY: begin
          if (food_strobe) begin
            increment <= 1'b1;
            score     <= score + SCORE_W'(1);
          end
          if (game_over) begin
            state   <= ST_ARM;
            en      <= ~food_strobe;
            playing <= 1'b0;
            decider <= DEC_SELF;
          end
        end
        ST_ARM: begin
          if (!en) begin
            en <= 1'b1;
          end else begin
            state     <= ST_COMMIT;
            increment <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_REVIEW;
          dwell <= '0;
        end
        ST_REVIEW: begin
          if (start_rise) begin
            state   <= ST_PLAY;
            playing <= 1'b1;
            en      <= 1'b0;
            decider <= DEC_SELF;
            score   <= '0;
            dwell   <= '0;
          end else if (key_rise || (dwell == DWELL_LAST)) begin
            // Key press and dwell expiry in the same cycle give one advance
            decider <= next_page(decider);
            dwell   <= '0;
          end else begin
            dwell <= dwell + DWELL_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
